inst_sram_responder: RTL and testbench

INST_SRAM_RESPONDER -- requirements
Module: inst_sram_responder

---
 rtl/inst_sram_responder_pkg.sv | 40 ++++
 rtl/inst_sram_responder_byte_write_ram.sv | 45 ++++
 rtl/inst_sram_responder.sv | 85 ++++++++
 tb/tb_inst_sram_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_responder_pkg.sv
// Shared types and constants for the instruction SRAM responder.
// cpu_core_params holds the core-wide bus types; inst_sram_params holds the SRAM-specific ones.

package cpu_core_params;

    typedef logic [31:0] Address;
    typedef logic [31:0] CpuData;

endpackage

package inst_sram_params;

    localparam int                      DEFAULT_DEPTH_WORDS  = 4096;
    localparam cpu_core_params::Address DEFAULT_BASE_ADDRESS = 32'hbfc00000;
    localparam logic [15:0]             ERROR_COUNT_MAX      = 16'hffff;

    // Word index derived from a byte offset (offset[31:2]).
    typedef logic [29:0] WordIndex;

    // Replace the bytes of old_word whose strobe bit is set with the matching bytes of new_word.
    function automatic cpu_core_params::CpuData merge_bytes(
        input cpu_core_params::CpuData old_word,
        input cpu_core_params::CpuData new_word,
        input logic [3:0]              strobe
    );
        cpu_core_params::CpuData merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strobe[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic [15:0] saturating_increment(input logic [15:0] value);
        return (value == ERROR_COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/inst_sram_responder_byte_write_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Define INST_SRAM_WRITE_FIRST_EN for write-first read data on write cycles; default is read-first.

module byte_write_ram
    import inst_sram_params::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int INDEX_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                    clock_i,
    input  logic                    enable_i,
    input  logic [3:0]              write_strobe_i,
    input  logic [INDEX_WIDTH-1:0]  word_index_i,
    input  cpu_core_params::CpuData write_data_i,
    output cpu_core_params::CpuData read_data_o
);

    cpu_core_params::CpuData mem_q [DEPTH_WORDS];
    cpu_core_params::CpuData read_data_q;

    // Storage is deliberately never reset; contents survive the core's reset.
    always_ff @(posedge clock_i) begin
        if (enable_i) begin
            for (int b = 0; b < 4; b++) begin
                if (write_strobe_i[b]) begin
                    mem_q[word_index_i][8*b +: 8] <= write_data_i[8*b +: 8];
                end
            end
        end
    end

    // Read register only moves on an accepted access, which is what lets IF stall on it.
    always_ff @(posedge clock_i) begin
        if (enable_i) begin
`ifdef INST_SRAM_WRITE_FIRST_EN
            read_data_q <= merge_bytes(mem_q[word_index_i], write_data_i, write_strobe_i);
`else
            read_data_q <= mem_q[word_index_i];
`endif
        end
    end

    assign read_data_o = read_data_q;

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-side SRAM responder: address decode, range/alignment checking and error reporting
// around byte_write_ram. Optional macro INST_SRAM_WRITE_FIRST_EN selects write-first read data.

module inst_sram_responder
    import inst_sram_params::*;
#(
    parameter int                      DEPTH_WORDS  = DEFAULT_DEPTH_WORDS,
    parameter cpu_core_params::Address BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    instruction_enabled,
    input  logic [3:0]              instruction_write_strobe,
    input  cpu_core_params::Address instruction_address,
    input  cpu_core_params::CpuData instruction_write_data,
    output cpu_core_params::CpuData instruction_read_data,
    output logic                    access_error,
    output logic [15:0]             error_count
);

    localparam int INDEX_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    WordIndex                word_index;
    logic                    in_range;
    logic                    aligned;
    logic                    access_valid;
    logic                    take_access;
    logic                    ram_enable;
    cpu_core_params::CpuData ram_read_data;

    logic                    access_error_q, access_error_d;
    logic [15:0]             error_count_q, error_count_d;
    logic                    suppress_data_q, suppress_data_d;

    // offset < DEPTH*4 is equivalent to offset[31:2] < DEPTH because DEPTH*4 is word aligned.
    assign word_index   = WordIndex'((instruction_address - BASE_ADDRESS) >> 2);
    assign in_range     = word_index < WordIndex'(DEPTH_WORDS);
    assign aligned      = instruction_address[1:0] == 2'b00;
    assign access_valid = in_range && aligned;
    assign take_access  = instruction_enabled && !reset;
    assign ram_enable   = take_access && access_valid;

    byte_write_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_ram (
        .clock_i        (clock),
        .enable_i       (ram_enable),
        .write_strobe_i (instruction_write_strobe),
        .word_index_i   (word_index[INDEX_WIDTH-1:0]),
        .write_data_i   (instruction_write_data),
        .read_data_o    (ram_read_data)
    );

    // suppress_data forces zero read data after reset or an invalid access, without touching the RAM.
    always_comb begin
        access_error_d  = access_error_q;
        error_count_d   = error_count_q;
        suppress_data_d = suppress_data_q;
        if (instruction_enabled) begin
            access_error_d  = !access_valid;
            suppress_data_d = !access_valid;
            if (!access_valid) begin
                error_count_d = saturating_increment(error_count_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            access_error_q  <= 1'b0;
            error_count_q   <= 16'h0000;
            suppress_data_q <= 1'b1;
        end else begin
            access_error_q  <= access_error_d;
            error_count_q   <= error_count_d;
            suppress_data_q <= suppress_data_d;
        end
    end

    assign instruction_read_data = suppress_data_q ? 32'h0 : ram_read_data;
    assign access_error          = access_error_q;
    assign error_count           = error_count_q;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder: directed scenarios plus a randomized run
// against a word-level reference model of the responder.

module tb_inst_sram_responder;

    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'hbfc00000;
    localparam int          WINDOW = 16;
`ifdef INST_SRAM_WRITE_FIRST_EN
    localparam bit WRITE_FIRST = 1'b1;
`else
    localparam bit WRITE_FIRST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        instruction_enabled;
    logic [3:0]  instruction_write_strobe;
    logic [31:0] instruction_address;
    logic [31:0] instruction_write_data;
    logic [31:0] instruction_read_data;
    logic        access_error;
    logic [15:0] error_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [WINDOW];
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_cnt;

    inst_sram_responder #(
        .DEPTH_WORDS  (DEPTH),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .instruction_enabled      (instruction_enabled),
        .instruction_write_strobe (instruction_write_strobe),
        .instruction_address      (instruction_address),
        .instruction_write_data   (instruction_write_data),
        .instruction_read_data    (instruction_read_data),
        .access_error             (access_error),
        .error_count              (error_count)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: what one clock edge does to the observable state, given the current inputs.
    task automatic model_step();
        logic [31:0] off;
        logic [31:0] old_word;
        logic [31:0] new_word;
        int          idx;
        if (reset) begin
            exp_rd  = 32'h0;
            exp_err = 1'b0;
            exp_cnt = 16'h0;
        end else if (instruction_enabled) begin
            off = instruction_address - BASE;
            if ((longint'(off) < longint'(DEPTH) * 4) && (instruction_address % 4 == 0)) begin
                idx      = int'(off / 4);
                old_word = (idx < WINDOW) ? model_mem[idx] : 32'hx;
                new_word = old_word;
                for (int b = 0; b < 4; b++) begin
                    if (instruction_write_strobe[b]) new_word[8*b +: 8] = instruction_write_data[8*b +: 8];
                end
                if (idx < WINDOW) model_mem[idx] = new_word;
                exp_rd  = (instruction_write_strobe != 4'b0 && WRITE_FIRST) ? new_word : old_word;
                exp_err = 1'b0;
            end else begin
                exp_rd  = 32'h0;
                exp_err = 1'b1;
                if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
            end
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wd);
        instruction_enabled      = en;
        instruction_write_strobe = strb;
        instruction_address      = addr;
        instruction_write_data   = wd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 4'h0, BASE, 32'h0);
        tick();
        tick();
        vectors++;
        if (instruction_read_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rd got %h want %h", instruction_read_data, 32'h0);
        end
        vectors++;
        if (access_error !== 1'b0 || error_count !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_err got err=%b cnt=%h want err=0 cnt=0000", access_error, error_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_preload_read();
        for (int i = 0; i < WINDOW; i++) begin
            drive(1'b1, 4'hf, BASE + 32'(i * 4), $urandom);
            tick();
        end
        drive(1'b1, 4'hf, BASE, 32'h24080001);
        tick();
        drive(1'b1, 4'h0, BASE, 32'h0);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h24080001) begin
            miscompares++;
            $display("[TB] FAIL preload_rd got %h want %h", instruction_read_data, 32'h24080001);
        end
        vectors++;
        if (access_error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL preload_err got %b want 0", access_error);
        end
    endtask

    task automatic test_stall_hold();
        drive(1'b1, 4'hf, BASE + 32'h4, 32'h11112222);
        tick();
        drive(1'b1, 4'h0, BASE + 32'h4, 32'h0);
        tick();
        drive(1'b0, 4'hf, BASE + 32'h8, 32'hffffffff);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (instruction_read_data !== 32'h11112222 || access_error !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d] got %h err=%b want 11112222 err=0", i, instruction_read_data, access_error);
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] want_wr;
        want_wr = WRITE_FIRST ? 32'h00bb00dd : 32'h0;
        drive(1'b1, 4'hf, BASE + 32'hc, 32'h0);
        tick();
        drive(1'b1, 4'b0101, BASE + 32'hc, 32'haabbccdd);
        tick();
        vectors++;
        if (instruction_read_data !== want_wr) begin
            miscompares++;
            $display("[TB] FAIL strobe_write_cycle got %h want %h", instruction_read_data, want_wr);
        end
        drive(1'b1, 4'h0, BASE + 32'hc, 32'h0);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h00bb00dd) begin
            miscompares++;
            $display("[TB] FAIL strobe_readback got %h want %h", instruction_read_data, 32'h00bb00dd);
        end
    endtask

    task automatic test_errors();
        reset = 1'b1;
        drive(1'b0, 4'h0, BASE, 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b1, 4'h0, 32'hbfc10000, 32'h0);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h0 || access_error !== 1'b1 || error_count !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL err_range got rd=%h err=%b cnt=%h want 0/1/0001", instruction_read_data, access_error, error_count);
        end
        drive(1'b1, 4'hf, 32'hbfc00002, 32'hdeadbeef);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h0 || access_error !== 1'b1 || error_count !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL err_misalign got rd=%h err=%b cnt=%h want 0/1/0002", instruction_read_data, access_error, error_count);
        end
        drive(1'b0, 4'h0, BASE, 32'h0);
        tick();
        vectors++;
        if (access_error !== 1'b1 || error_count !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL err_hold got err=%b cnt=%h want 1/0002", access_error, error_count);
        end
        drive(1'b1, 4'h0, BASE, 32'h0);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h24080001 || access_error !== 1'b0 || error_count !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL err_clear got rd=%h err=%b cnt=%h want 24080001/0/0002", instruction_read_data, access_error, error_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
            tick();
            vectors++;
            if (instruction_read_data !== exp_rd || access_error !== exp_err) begin
                miscompares++;
                $display("[TB] FAIL b2b[%0d] got %h err=%b want %h err=%b", i, instruction_read_data, access_error, exp_rd, exp_err);
            end
        end
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] addr;
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                7:       addr = BASE + 32'($urandom_range(0, WINDOW - 1) * 4) + 32'($urandom_range(1, 3));
                8:       addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
                9:       addr = BASE - 32'($urandom_range(1, 64) * 4);
                default: addr = BASE + 32'($urandom_range(0, WINDOW - 1) * 4);
            endcase
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), addr, $urandom);
            tick();
            vectors++;
            if (instruction_read_data !== exp_rd || access_error !== exp_err || error_count !== exp_cnt) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] got rd=%h err=%b cnt=%h want rd=%h err=%b cnt=%h",
                         i, instruction_read_data, access_error, error_count, exp_rd, exp_err, exp_cnt);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        drive(1'b0, 4'h0, BASE, 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 65540; i++) begin
            drive(1'b1, 4'h0, 32'hbfc10000, 32'h0);
            tick();
            if (i == 1000 || i == 65534 || i == 65535) begin
                vectors++;
                if (error_count !== exp_cnt) begin
                    miscompares++;
                    $display("[TB] FAIL sat_progress[%0d] got %h want %h", i, error_count, exp_cnt);
                end
            end
        end
        vectors++;
        if (error_count !== 16'hffff || access_error !== 1'b1 || instruction_read_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL sat_final got cnt=%h err=%b rd=%h want ffff/1/0", error_count, access_error, instruction_read_data);
        end
    endtask

    task automatic test_reset_during_write();
        drive(1'b1, 4'hf, BASE + 32'h8, 32'h12345678);
        tick();
        drive(1'b1, 4'h0, BASE + 32'h8, 32'h0);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h12345678) begin
            miscompares++;
            $display("[TB] FAIL rst_inflight_rd got %h want %h", instruction_read_data, 32'h12345678);
        end
        reset = 1'b1;
        drive(1'b1, 4'hf, BASE + 32'h8, 32'hdeadbeef);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h0 || access_error !== 1'b0 || error_count !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_write_outputs got rd=%h err=%b cnt=%h want 0/0/0000", instruction_read_data, access_error, error_count);
        end
        reset = 1'b0;
        drive(1'b0, 4'h0, BASE, 32'h0);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_idle_rd got %h want %h", instruction_read_data, 32'h0);
        end
        drive(1'b1, 4'h0, BASE + 32'h8, 32'h0);
        tick();
        vectors++;
        if (instruction_read_data !== 32'h12345678 || instruction_read_data !== exp_rd) begin
            miscompares++;
            $display("[TB] FAIL rst_word_kept got %h want %h", instruction_read_data, 32'h12345678);
        end
    endtask

    initial begin
        exp_rd  = 32'h0;
        exp_err = 1'b0;
        exp_cnt = 16'h0;
        for (int i = 0; i < WINDOW; i++) model_mem[i] = 32'h0;
        reset = 1'b0;
        drive(1'b0, 4'h0, BASE, 32'h0);
        @(posedge clock);
        #1;
        test_reset();
        test_preload_read();
        test_stall_hold();
        test_byte_strobe();
        test_errors();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_during_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
